// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor front end.
package proc_pkg;

    localparam int unsigned PC_W         = 10;
    localparam int unsigned INSTR_W      = 9;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned NUM_PROGRAMS = 3;
    localparam logic [INSTR_W-1:0] HALT_WORD = 9'b010000000;
    localparam int unsigned PROG0_BASE   = 0;
    localparam int unsigned PROG1_BASE   = 256;
    localparam int unsigned PROG2_BASE   = 512;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        HALTED,
        FINISHED
    } fetch_state_t;

    // Start address of the program run selected by idx; indices past the
    // last program fall back to the final base.
    function automatic int unsigned prog_base(input logic [1:0] idx,
                                              input int unsigned b0,
                                              input int unsigned b1,
                                              input int unsigned b2);
        case (idx)
            2'd0:    return b0;
            2'd1:    return b1;
            default: return b2;
        endcase
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with its next-pc priority mux.
// A base load wins over everything. Otherwise the pc only moves while
// advance is high. Within an advance, hold beats branch, and branch beats
// increment.
module fetch_pc_reg #(
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    input  logic            advance,
    input  logic            hold,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_next;

    // Next-pc selection; the increment wraps naturally mod 2^PC_W.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_addr;
        end else if (advance) begin
            if (hold) begin
                pc_next = pc;
            end else if (branch_taken) begin
                pc_next = branch_target;
            end else begin
                pc_next = pc + PC_W'(1);
            end
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end. It owns the pc, issues instructions to decode, detects
// the halt word, and runs the start/done handshake across the program runs.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned        PC_W         = proc_pkg::PC_W,
    parameter int unsigned        INSTR_W      = proc_pkg::INSTR_W,
    parameter int unsigned        NUM_PROGRAMS = proc_pkg::NUM_PROGRAMS,
    parameter logic [INSTR_W-1:0] HALT_WORD    = proc_pkg::HALT_WORD,
    parameter int unsigned        PROG0_BASE   = proc_pkg::PROG0_BASE,
    parameter int unsigned        PROG1_BASE   = proc_pkg::PROG1_BASE,
    parameter int unsigned        PROG2_BASE   = proc_pkg::PROG2_BASE,
    parameter int unsigned        CNT_W        = proc_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               done,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [1:0]         prog_idx,
    output logic [CNT_W-1:0]   cycle_count
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] base_addr;
    logic            is_halt;
    logic            last_prog;
    logic            load_pc;
    logic            run_adv;

    // The cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign is_halt   = (imem_data == HALT_WORD);
    assign last_prog = (prog_idx == 2'(NUM_PROGRAMS - 1));
    assign base_addr = PC_W'(prog_base(prog_idx, PROG0_BASE, PROG1_BASE, PROG2_BASE));
    assign imem_addr = pc;
    assign instr_out = imem_data;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (PC_W'(PROG0_BASE))
    ) u_pc (
        .clk           (clk),
        .reset         (reset),
        .load          (load_pc),
        .load_addr     (base_addr),
        .advance       (run_adv),
        .hold          (is_halt || stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; done follows the registered state,
    // so it rises the cycle after the halt word is seen.
    always_comb begin
        state_next  = state;
        done        = 1'b0;
        instr_valid = 1'b0;
        load_pc     = 1'b0;
        run_adv     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ARMED;
            end
            ARMED: begin
                if (!start) begin
                    state_next = RUN;
                    load_pc    = 1'b1;
                end
            end
            RUN: begin
                run_adv     = 1'b1;
                instr_valid = !is_halt;
                if (is_halt) state_next = last_prog ? FINISHED : HALTED;
            end
            HALTED: begin
                done = 1'b1;
                if (start) state_next = ARMED;
            end
            FINISHED: begin
                done = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Program index advances on each halt except the one that finishes.
    // The cycle counter clears at launch, counts RUN cycles, and holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prog_idx    <= '0;
            cycle_count <= '0;
        end else begin
            if (state == RUN && is_halt && !last_prog) begin
                prog_idx <= prog_idx + 2'd1;
            end
            if (state == ARMED && !start) begin
                cycle_count <= '0;
            end else if (state == RUN) begin
                cycle_count <= sat_inc(cycle_count);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected issues and
// done events, monitors pop and compare when the DUT presents them.
module tb_fetch_sequencer;

    localparam logic [8:0] HALT = 9'b010000000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [9:0] imem_addr;
    logic [8:0] imem_data;
    logic [8:0] instr_out;
    logic       instr_valid;
    logic       stall;
    logic       branch_taken;
    logic [9:0] branch_target;
    logic [1:0] prog_idx;
    logic [15:0] cycle_count;

    logic [8:0] mem [1024];

    logic       br_en = 1'b0;
    logic [9:0] br_at = '0;
    logic [9:0] br_tgt = '0;
    logic [9:0] stall_at = '0;
    int         stall_n = 0;
    int         hits;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [9:0] a; logic [8:0] d; } vexp_t;
    typedef struct { logic [1:0] idx; logic [15:0] cnt; } dexp_t;
    vexp_t vq[$];
    dexp_t dq[$];
    logic  prev_done = 1'b0;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .done          (done),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .prog_idx      (prog_idx),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    assign imem_data     = mem[imem_addr];
    assign branch_taken  = br_en && (imem_addr == br_at);
    assign branch_target = br_tgt;
    assign stall         = (imem_addr == stall_at) && (hits < stall_n);

    always @(posedge clk) begin
        if (!reset) hits <= 0;
        else if (stall) hits <= hits + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue monitor.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (vq.size() == 0) begin
                check("unexpected_issue_addr", {22'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                vexp_t e;
                e = vq.pop_front();
                check("issue_addr", {22'd0, imem_addr}, {22'd0, e.a});
                check("issue_instr", {23'd0, instr_out}, {23'd0, e.d});
            end
        end
    end

    // Done-rise monitor.
    always @(negedge clk) begin
        if (!prev_done && done === 1'b1) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                dexp_t e;
                e = dq.pop_front();
                check("done_prog_idx", {30'd0, prog_idx}, {30'd0, e.idx});
                check("done_cycle_count", {16'd0, cycle_count}, {16'd0, e.cnt});
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic push_v(input logic [9:0] a, input logic [8:0] d);
        vexp_t e;
        e.a = a; e.d = d;
        vq.push_back(e);
    endtask

    task automatic push_d(input logic [1:0] idx, input logic [15:0] cnt);
        dexp_t e;
        e.idx = idx; e.cnt = cnt;
        dq.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
        check(name, {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Plain program 0, with reset-state checks.
        clear_mem();
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = HALT;
        do_reset();
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_prog_idx", {30'd0, prog_idx}, 32'd0);
        check("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
        check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        push_v(10'd0, 9'h001); push_v(10'd1, 9'h002);
        push_d(2'd1, 16'd3);
        pulse_start();
        wait_done("t1_done");
        check("t1_halt_pc", {22'd0, imem_addr}, 32'd2);

        // Branch at 1 to 40; address 2 must never issue.
        clear_mem();
        mem[0] = 9'h010; mem[1] = 9'h011; mem[2] = 9'h0AA; mem[40] = HALT;
        br_en = 1'b1; br_at = 10'd1; br_tgt = 10'd40;
        do_reset();
        push_v(10'd0, 9'h010); push_v(10'd1, 9'h011);
        push_d(2'd1, 16'd3);
        pulse_start();
        wait_done("t2_done");
        check("t2_halt_pc", {22'd0, imem_addr}, 32'd40);
        br_en = 1'b0;

        // Stall three cycles at address 1.
        clear_mem();
        mem[0] = 9'h021; mem[1] = 9'h022; mem[2] = 9'h023; mem[3] = HALT;
        stall_at = 10'd1; stall_n = 3;
        do_reset();
        push_v(10'd0, 9'h021);
        for (int k = 0; k < 4; k++) push_v(10'd1, 9'h022);
        push_v(10'd2, 9'h023);
        push_d(2'd1, 16'd7);
        pulse_start();
        wait_done("t3_done");
        stall_n = 0;

        // Halt together with branch and stall: halt wins, pc stays.
        clear_mem();
        mem[0] = 9'h031; mem[1] = HALT;
        br_en = 1'b1; br_at = 10'd1; br_tgt = 10'd40;
        stall_at = 10'd1; stall_n = 1;
        do_reset();
        push_v(10'd0, 9'h031);
        push_d(2'd1, 16'd2);
        pulse_start();
        wait_done("t4_done");
        check("t4_pc_held", {22'd0, imem_addr}, 32'd1);
        check("t4_no_valid", {31'd0, instr_valid}, 32'd0);
        br_en = 1'b0; stall_n = 0;

        // Three back-to-back runs, then FINISHED ignores start.
        clear_mem();
        mem[0] = 9'h041; mem[1] = HALT;
        mem[256] = 9'h042; mem[257] = 9'h043; mem[258] = HALT;
        mem[512] = 9'h044; mem[513] = HALT;
        do_reset();
        push_v(10'd0, 9'h041); push_d(2'd1, 16'd2);
        pulse_start();
        wait_done("t5_run0_done");
        push_v(10'd256, 9'h042); push_v(10'd257, 9'h043); push_d(2'd2, 16'd3);
        pulse_start();
        wait_done("t5_run1_done");
        push_v(10'd512, 9'h044); push_d(2'd2, 16'd2);
        pulse_start();
        wait_done("t5_run2_done");
        pulse_start();
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        check("t5_fin_done", {31'd0, done}, 32'd1);
        check("t5_fin_addr", {22'd0, imem_addr}, 32'd513);
        check("t5_fin_valid", {31'd0, instr_valid}, 32'd0);
        check("t5_fin_idx", {30'd0, prog_idx}, 32'd2);

        // Reset mid-run at address 5 of program 1, then restart.
        clear_mem();
        mem[0] = 9'h041; mem[1] = HALT;
        for (int k = 0; k < 10; k++) mem[256 + k] = 9'h050 + 9'(k);
        do_reset();
        push_v(10'd0, 9'h041); push_d(2'd1, 16'd2);
        pulse_start();
        wait_done("t6_run0_done");
        for (int k = 0; k < 6; k++) push_v(10'(256 + k), 9'h050 + 9'(k));
        pulse_start();
        begin
            int n;
            n = 0;
            while (imem_addr !== 10'd261 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t6_reached_261", {22'd0, imem_addr}, 32'd261);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_idx", {30'd0, prog_idx}, 32'd0);
        check("t6_rst_pc", {22'd0, imem_addr}, 32'd0);
        check("t6_rst_cnt", {16'd0, cycle_count}, 32'd0);
        check("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        reset = 1'b1;
        push_v(10'd0, 9'h041); push_d(2'd1, 16'd2);
        pulse_start();
        wait_done("t6_restart_done");

        repeat (3) @(negedge clk);
        check("issue_queue_drained", vq.size(), 32'd0);
        check("done_queue_drained", dq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end stage of the 9-bit processor. It owns the program counter and drives the instruction-memory address. It presents each fetched instruction to the decode/execute datapath and detects the halt word. It also runs the start/done handshake with the testbench across NUM_PROGRAMS back-to-back program runs, each starting at its own base address.

Parameters:
PC_W, 10, program-counter and instruction-memory address width
INSTR_W, 9, instruction width
NUM_PROGRAMS, 3, number of program runs before permanent finish
HALT_WORD, 9'b010000000, instruction encoding that ends a program
PROG0_BASE, 0, start address of program 0
PROG1_BASE, 256, start address of program 1
PROG2_BASE, 512, start address of program 2
CNT_W, 16, per-run cycle counter width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
start  in  1  testbench handshake; a high-then-low sequence launches the next program
done  out  1  high while current program halted or all programs finished
imem_addr  out  PC_W  instruction-memory address, equals pc
imem_data  in  INSTR_W  instruction-memory read data, combinational from imem_addr
instr_out  out  INSTR_W  instruction presented to decode, equals imem_data
instr_valid  out  1  instr_out is a real instruction to execute this cycle
stall  in  1  datapath request to hold the current instruction (multi-cycle memory op)
branch_taken  in  1  decode/ALU resolved a taken branch for the current instr_out
branch_target  in  PC_W  absolute target address when branch_taken
prog_idx  out  2  index of the current or most recent program run
cycle_count  out  CNT_W  RUN cycles elapsed in the current run

Behaviour:
- Reset: state=IDLE, pc=PROG0_BASE, done=0, prog_idx=0, cycle_count=0. instr_valid=0 whenever state≠RUN.
- States:
  - IDLE: wait for start=1, then go to ARMED.
  - ARMED: wait for start=0, then go to RUN and load pc=base[prog_idx].
  - RUN: fetch and issue instructions (rules below).
  - HALTED: done=1. On start=1, clear done next cycle and go to ARMED.
  - FINISHED: absorbing state, done=1; only reset leaves it.
- RUN, each cycle:
  - imem_addr=pc.
  - instr_valid = (imem_data≠HALT_WORD).
  - cycle_count increments, saturating at all-ones.
- RUN pc update priority (highest first):
  - imem_data==HALT_WORD → pc holds. Next state is HALTED, or FINISHED if prog_idx==NUM_PROGRAMS-1. done=1 from the next cycle. prog_idx increments, except it does not increment on entry to FINISHED.
  - stall=1 → pc holds; the same instruction is presented again with instr_valid=1.
  - branch_taken=1 → pc=branch_target.
  - otherwise pc=pc+1, wrapping mod 2^PC_W.
- Halt beats simultaneous stall or branch_taken; the halt word is never issued as valid.
- Latency: first instruction of a run appears the cycle after start is observed low in ARMED. One instruction per cycle absent stall.
- start changes during RUN are ignored. start already high on entering HALTED counts as the launching high.
- cycle_count clears on ARMED→RUN and holds in HALTED/FINISHED for readback.
- branch_taken and branch_target are ignored outside RUN or when instr_valid=0.
- reset asserted in any state overrides all other inputs and returns to the reset values above.

Decomposition:
- Shared package (proc_pkg):
  - fetch_state_t enum {IDLE, ARMED, RUN, HALTED, FINISHED}
  - HALT_WORD, INSTR_W, PC_W constants
  - function returning the base address for a prog_idx
- One natural sub-module, fetch_pc_reg: the PC register with next-pc priority mux (load base, hold, branch, increment).
- FSM, handshake and counter stay in fetch_sequencer.

Test Plan:
- Reset then start 1→0; imem holds 0x001,0x002,HALT at 0..2 → instr_valid for 2 cycles, addrs 0,1,2; done=1 the cycle after addr 2; prog_idx=1; cycle_count=3.
- Branch: at addr 1 assert branch_taken with target 40; HALT at 40 → imem_addr sequence 0,1,40; done rises; instruction at addr 2 never fetched.
- Stall held 3 cycles at addr 1 → addr 1 presented 4 consecutive cycles with instr_valid=1; pc advances to 2 only after stall drops.
- Three runs: start pulse after each done → runs begin at 0, 256, 512. After the third HALT, state is FINISHED with done=1, and further start pulses leave done=1 with imem_addr frozen.
- Simultaneous halt+branch_taken+stall at one address → halt wins: instr_valid=0, done=1 next cycle, pc unchanged.
- reset driven 0 mid-RUN at addr 5 of program 1 → next cycle done=0, prog_idx=0, pc=0, state IDLE; run restarts from PROG0_BASE after a new start pulse.
